// File: rtl/lc3b_control_ext_if.sv
// LC-3b control types and unified memory port.
// Controller drives strobes; memory returns mem_resp.
package lc3b_ctl_pkg;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [2:0] {
    alu_add  = 3'd0,
    alu_and  = 3'd1,
    alu_not  = 3'd2,
    alu_pass = 3'd3,
    alu_sll  = 3'd4,
    alu_srl  = 3'd5,
    alu_sra  = 3'd6
  } lc3b_aluop;

endpackage

interface lc3b_control_ext_if;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] mem_byte_enable;
  logic       mem_resp;

  modport master (
    output mem_read,
    output mem_write,
    output mem_byte_enable,
    input  mem_resp
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_byte_enable,
    output mem_resp
  );
endinterface

// File: rtl/lc3b_control_ext.sv
// Multicycle LC-3b control FSM with byte/indirect/trap
// support, memory watchdog and retired-instruction count.
module lc3b_control_ext
  import lc3b_ctl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  lc3b_opcode     opcode,
  input  logic           ir_bit11,
  input  logic           ir_bit5,
  input  logic           ir_bit4,
  input  logic           mar_lsb,
  input  logic           branch_enable,
  lc3b_control_ext_if.master mem,
  output logic           load_pc,
  output logic           load_ir,
  output logic           load_regfile,
  output logic           load_mar,
  output logic           load_mdr,
  output logic           load_cc,
  output logic [1:0]     pcmux_sel,
  output logic [2:0]     regfilemux_sel,
  output logic [1:0]     marmux_sel,
  output logic           mdrmux_sel,
  output logic [1:0]     alumux_sel,
  output logic           storemux_sel,
  output logic           destmux_sel,
  output logic           pcoffsetmux_sel,
  output lc3b_aluop      aluop,
  output logic           fault,
  output logic [CNT_WIDTH-1:0] instr_retired
);

  typedef enum logic [4:0] {
    FETCH1, FETCH2, FETCH3, DECODE,
    S_ADD, S_AND, S_NOT, S_SHF,
    BR_TAKEN, S_JMP, JSR1, JSR2, S_LEA,
    CALC_ADDR, CALC_BADDR,
    LDR1, LDR2, LDB1, LDB2,
    STR1, STR2, STB1, STB2,
    LDI1, LDI2, STI1, STI2,
    TRAP1, TRAP2, TRAP3,
    S_FAULT
  } state_t;

  localparam int WD_W =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit WD_EN = (MEM_TIMEOUT > 0);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t          state;
  state_t          next;
  logic            retire;
  logic            mem_state;
  logic            timeout;
  logic [WD_W-1:0] wd_cnt;

  assign mem_state = state inside {
    FETCH2, LDR1, LDB1, STR2, STB2,
    LDI1, STI1, TRAP2
  };

  // strobe held past the limit with no response
  assign timeout = WD_EN && mem_state &&
                   !mem.mem_resp && (wd_cnt == WD_LAST);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH1;
    else     state <= next;
  end

  // watchdog: counts stalled memory cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wd_cnt <= '0;
    else if (!WD_EN || !mem_state || mem.mem_resp)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + WD_W'(1);
  end

  // retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      instr_retired <= '0;
    else if (retire)
      instr_retired <= instr_retired + CNT_WIDTH'(1);
  end

  // next state and per-state control outputs
  always_comb begin
    next                = state;
    retire              = 1'b0;
    load_pc             = 1'b0;
    load_ir             = 1'b0;
    load_regfile        = 1'b0;
    load_mar            = 1'b0;
    load_mdr            = 1'b0;
    load_cc             = 1'b0;
    pcmux_sel           = 2'd0;
    regfilemux_sel      = 3'd0;
    marmux_sel          = 2'd0;
    mdrmux_sel          = 1'b0;
    alumux_sel          = 2'd0;
    storemux_sel        = 1'b0;
    destmux_sel         = 1'b0;
    pcoffsetmux_sel     = 1'b0;
    aluop               = alu_add;
    mem.mem_read        = 1'b0;
    mem.mem_write       = 1'b0;
    mem.mem_byte_enable = 2'b11;
    fault               = 1'b0;

    if (!rst) begin
      unique case (state)
        FETCH1: begin
          marmux_sel = 2'd1;
          load_mar   = 1'b1;
          load_pc    = 1'b1;
          next       = FETCH2;
        end
        FETCH2: begin
          mem.mem_read = 1'b1;
          mdrmux_sel   = 1'b1;
          load_mdr     = 1'b1;
          if (mem.mem_resp) next = FETCH3;
        end
        FETCH3: begin
          load_ir = 1'b1;
          next    = DECODE;
        end
        DECODE: begin
          unique case (opcode)
            op_add: next = S_ADD;
            op_and: next = S_AND;
            op_not: next = S_NOT;
            op_shf: next = S_SHF;
            op_br: begin
              if (branch_enable) begin
                next = BR_TAKEN;
              end else begin
                next   = FETCH1;
                retire = 1'b1;
              end
            end
            op_jmp:  next = S_JMP;
            op_jsr:  next = JSR1;
            op_lea:  next = S_LEA;
            op_ldr,
            op_str,
            op_ldi,
            op_sti:  next = CALC_ADDR;
            op_ldb,
            op_stb:  next = CALC_BADDR;
            op_trap: next = TRAP1;
            default: next = FETCH1;
          endcase
        end
        S_ADD: begin
          alumux_sel   = ir_bit5 ? 2'd2 : 2'd0;
          load_regfile = 1'b1;
          load_cc      = 1'b1;
          retire       = 1'b1;
          next         = FETCH1;
        end
        S_AND: begin
          aluop        = alu_and;
          alumux_sel   = ir_bit5 ? 2'd2 : 2'd0;
          load_regfile = 1'b1;
          load_cc      = 1'b1;
          retire       = 1'b1;
          next         = FETCH1;
        end
        S_NOT: begin
          aluop        = alu_not;
          load_regfile = 1'b1;
          load_cc      = 1'b1;
          retire       = 1'b1;
          next         = FETCH1;
        end
        S_SHF: begin
          if (!ir_bit4)     aluop = alu_sll;
          else if (ir_bit5) aluop = alu_sra;
          else              aluop = alu_srl;
          alumux_sel   = 2'd2;
          load_regfile = 1'b1;
          load_cc      = 1'b1;
          retire       = 1'b1;
          next         = FETCH1;
        end
        BR_TAKEN: begin
          pcoffsetmux_sel = 1'b0;
          pcmux_sel       = 2'd1;
          load_pc         = 1'b1;
          retire          = 1'b1;
          next            = FETCH1;
        end
        S_JMP: begin
          pcmux_sel = 2'd2;
          aluop     = alu_pass;
          load_pc   = 1'b1;
          retire    = 1'b1;
          next      = FETCH1;
        end
        JSR1: begin
          destmux_sel    = 1'b1;
          regfilemux_sel = 3'd2;
          load_regfile   = 1'b1;
          next           = JSR2;
        end
        JSR2: begin
          if (ir_bit11) begin
            pcoffsetmux_sel = 1'b1;
            pcmux_sel       = 2'd1;
          end else begin
            pcmux_sel = 2'd2;
            aluop     = alu_pass;
          end
          load_pc = 1'b1;
          retire  = 1'b1;
          next    = FETCH1;
        end
        S_LEA: begin
          regfilemux_sel  = 3'd3;
          pcoffsetmux_sel = 1'b0;
          load_regfile    = 1'b1;
          load_cc         = 1'b1;
          retire          = 1'b1;
          next            = FETCH1;
        end
        CALC_ADDR: begin
          alumux_sel = 2'd1;
          load_mar   = 1'b1;
          if (opcode == op_ldr)      next = LDR1;
          else if (opcode == op_str) next = STR1;
          else if (opcode == op_ldi) next = LDI1;
          else                       next = STI1;
        end
        CALC_BADDR: begin
          alumux_sel = 2'd3;
          load_mar   = 1'b1;
          next = (opcode == op_stb) ? STB1 : LDB1;
        end
        LDR1: begin
          mem.mem_read = 1'b1;
          mdrmux_sel   = 1'b1;
          load_mdr     = 1'b1;
          if (mem.mem_resp) next = LDR2;
        end
        LDR2: begin
          regfilemux_sel = 3'd1;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
          retire         = 1'b1;
          next           = FETCH1;
        end
        LDB1: begin
          mem.mem_read = 1'b1;
          mdrmux_sel   = 1'b1;
          load_mdr     = 1'b1;
          if (mem.mem_resp) next = LDB2;
        end
        LDB2: begin
          regfilemux_sel = 3'd4;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
          retire         = 1'b1;
          next           = FETCH1;
        end
        STR1: begin
          storemux_sel = 1'b1;
          aluop        = alu_pass;
          load_mdr     = 1'b1;
          next         = STR2;
        end
        STR2: begin
          mem.mem_write = 1'b1;
          if (mem.mem_resp) begin
            retire = 1'b1;
            next   = FETCH1;
          end
        end
        STB1: begin
          storemux_sel = 1'b1;
          aluop        = alu_pass;
          load_mdr     = 1'b1;
          next         = STB2;
        end
        STB2: begin
          mem.mem_write       = 1'b1;
          mem.mem_byte_enable = mar_lsb ? 2'b10 : 2'b01;
          if (mem.mem_resp) begin
            retire = 1'b1;
            next   = FETCH1;
          end
        end
        LDI1: begin
          mem.mem_read = 1'b1;
          mdrmux_sel   = 1'b1;
          load_mdr     = 1'b1;
          if (mem.mem_resp) next = LDI2;
        end
        LDI2: begin
          marmux_sel = 2'd2;
          load_mar   = 1'b1;
          next       = LDR1;
        end
        STI1: begin
          mem.mem_read = 1'b1;
          mdrmux_sel   = 1'b1;
          load_mdr     = 1'b1;
          if (mem.mem_resp) next = STI2;
        end
        STI2: begin
          marmux_sel = 2'd2;
          load_mar   = 1'b1;
          next       = STR1;
        end
        TRAP1: begin
          marmux_sel     = 2'd3;
          load_mar       = 1'b1;
          destmux_sel    = 1'b1;
          regfilemux_sel = 3'd2;
          load_regfile   = 1'b1;
          next           = TRAP2;
        end
        TRAP2: begin
          mem.mem_read = 1'b1;
          mdrmux_sel   = 1'b1;
          load_mdr     = 1'b1;
          if (mem.mem_resp) next = TRAP3;
        end
        TRAP3: begin
          pcmux_sel = 2'd3;
          load_pc   = 1'b1;
          retire    = 1'b1;
          next      = FETCH1;
        end
        S_FAULT: begin
          fault = 1'b1;
        end
        default: next = FETCH1;
      endcase

      if (timeout) next = S_FAULT;
    end
  end

endmodule

// File: doc/lc3b_control_ext.md
Name: lc3b_control_ext

Overview:
- Next-generation multicycle control FSM for the LC-3b datapath.
- Adds new instructions beyond ADD/AND/NOT/BR/LDR/STR/JMP/JSR/LEA:
  - byte loads and stores: LDB, STB
  - indirect loads and stores: LDI, STI
  - shifts: SHF
  - JSRR
  - TRAP
- Adds a parametrised memory-handshake watchdog with a sticky fault state.
- Adds a retired-instruction counter.
- Sits between the datapath and the unified memory port. Drives every datapath load and mux select, plus the memory strobes.

Parameters:
- MEM_TIMEOUT, 0, maximum cycles to wait for mem_resp. 0 disables the watchdog.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  4  lc3b_opcode from IR[15:12].
- ir_bit11  in  1  JSR (1) vs JSRR (0).
- ir_bit5  in  1  immediate select for ADD/AND.
- ir_bit4  in  1  SHF direction: 0 = left, 1 = right.
- mar_lsb  in  1  MAR[0], the byte select.
- branch_enable  in  1  NZP match from the CC logic.
- mem_resp  in  1  memory completion.
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc  out  1 each  register loads.
- pcmux_sel  out  2  0 = PC+2, 1 = PC+offset adder, 2 = ALU/BaseR, 3 = MDR.
- regfilemux_sel  out  3  0 = ALU, 1 = MDR, 2 = PC, 3 = PC+offset adder, 4 = zero-extended MDR byte (byte chosen by mar_lsb).
- marmux_sel  out  2  0 = ALU, 1 = PC, 2 = MDR, 3 = zext(trapvect8)<<1.
- mdrmux_sel  out  1  0 = ALU, 1 = mem_rdata.
- alumux_sel  out  2  0 = SR2, 1 = sext(off6)<<1, 2 = sext(imm5), 3 = sext(off6).
- storemux_sel  out  1  0 = SR1 from IR[8:6], 1 = IR[11:9].
- destmux_sel  out  1  0 = IR[11:9], 1 = R7.
- pcoffsetmux_sel  out  1  0 = off9, 1 = off11.
- aluop  out  lc3b_aluop  ALU operation.
- mem_read, mem_write  out  1 each  memory strobes.
- mem_byte_enable  out  2  write mask.
- fault  out  1  sticky watchdog fault.
- instr_retired  out  CNT_WIDTH  count of completed instructions.

Behaviour:
- Default values, and values during reset, for every decode output:
  - all loads, strobes and fault = 0
  - all selects = 0
  - aluop = alu_add
  - mem_byte_enable = 2'b11
- Reset forces state = FETCH1, instr_retired = 0 and the watchdog counter = 0.
- Fetch and decode:
  - FETCH1: marmux = 1, load_mar, load_pc (pcmux = 0).
  - FETCH2: mem_read, mdrmux = 1, load_mdr. Holds until mem_resp.
  - FETCH3: load_ir.
  - DECODE: one cycle, no actions.
- ADD/AND: load_regfile, load_cc; alumux = 2 if ir_bit5, else 0.
- NOT: aluop = alu_not, load_regfile, load_cc.
- SHF: aluop = alu_sll if !ir_bit4, else alu_srl/alu_sra (sra when IR[5] = 1); alumux = 2; load_regfile, load_cc.
- BR: goes to BR_TAKEN if branch_enable, else FETCH1. BR_TAKEN: pcoffsetmux = 0, pcmux = 1, load_pc.
- JMP/RET: pcmux = 2, aluop = alu_pass, load_pc.
- JSR1: destmux = 1, regfilemux = 2, load_regfile.
- JSR2: load_pc.
  - ir_bit11 = 1: pcoffsetmux = 1, pcmux = 1.
  - ir_bit11 = 0: pcmux = 2, aluop = alu_pass.
  - Note: JSRR with BaseR = R7 uses the new R7. Software constraint; no hazard logic.
- LEA: regfilemux = 3, pcoffsetmux = 0, load_regfile, load_cc.
- Address calculation:
  - CALC_ADDR (LDR/STR/LDI/STI): alumux = 1, load_mar.
  - CALC_BADDR (LDB/STB): alumux = 3, load_mar.
- Loads:
  - LDR1/LDB1: read cycle (mem_read, mdrmux = 1, load_mdr), held until mem_resp.
  - LDR2: regfilemux = 1, load_regfile, load_cc.
  - LDB2: regfilemux = 4, load_regfile, load_cc.
- Stores:
  - STR1/STB1: storemux = 1, aluop = alu_pass, load_mdr.
  - STR2: mem_write, mask 2'b11, held until mem_resp.
  - STB2: mem_write, mask = mar_lsb ? 2'b10 : 2'b01, held until mem_resp.
- Indirect:
  - LDI1/STI1: read cycle, held until mem_resp.
  - LDI2/STI2: marmux = 2, load_mar.
  - LDI then continues LDR1 → LDR2; STI continues STR1 → STR2.
- TRAP:
  - TRAP1: marmux = 3, load_mar; destmux = 1, regfilemux = 2, load_regfile.
  - TRAP2: read cycle, held until mem_resp.
  - TRAP3: pcmux = 3, load_pc.
- Unknown or reserved opcode: DECODE → FETCH1 with no side effects. Not counted.
- Retirement:
  - instr_retired increments by 1 on the clock edge leaving the final state of each instruction: BR counts once whether taken or not.
  - Wraps modulo 2^CNT_WIDTH.
- Watchdog (MEM_TIMEOUT > 0):
  - The counter increments each cycle a strobe is held without mem_resp, and clears when mem_resp = 1 or the state is not a memory state.
  - When the counter equals MEM_TIMEOUT-1 and mem_resp = 0, the next state is FAULT.
  - mem_resp arriving in that same cycle wins: no fault.
  - FAULT: fault = 1, all strobes and loads = 0. Only rst exits FAULT.
- Reset mid-memory-access deasserts the strobes immediately (asynchronously).

Test Plan:
- ADD R1,R2,#-3 (ir_bit5 = 1), mem_resp after 2 wait cycles:
  - Sequence FETCH1, FETCH2 ×3, FETCH3, DECODE, ADD: 7 cycles.
  - alumux = 2, load_cc = 1 in ADD.
  - instr_retired 0 → 1.
- STB with mar_lsb = 1 → mem_byte_enable = 2'b10 in STB2 only; with mar_lsb = 0 → 2'b01.
- LDB with mar_lsb = 1 → regfilemux_sel = 4 in LDB2.
- LDI, mem_resp after 1 cycle per read → state order:
  - CALC_ADDR, LDI1, LDI2 (marmux = 2), LDR1, LDR2.
  - Exactly two mem_read phases after fetch.
- TRAP x25 → TRAP1 asserts marmux = 3, destmux = 1, regfilemux = 2; TRAP3 asserts pcmux = 3, load_pc.
- MEM_TIMEOUT = 4, mem_resp never asserted in FETCH2:
  - FAULT is entered after 4 FETCH2 cycles; fault = 1.
  - mem_read = 0 thereafter.
  - rst pulse → FETCH1, fault = 0.
  - Repeat with mem_resp in the 4th cycle → no fault.
- BR not taken, then BR taken → instr_retired +1 each; BR_TAKEN asserts pcmux = 1, load_pc.
